seg_scan_decoder: RTL

//  Receive end of the multiplexed 7-segment display interface: samples the scanned

---
 rtl/seg_scan_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Receive side of a scanned 7-segment display: waits for each digit's pattern to hold
// steady, then latches the decoded hex value, point, blank and invalid flags per digit.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [6:0]  SEGMENT,
  input  logic        p,
  output logic [15:0] hex,
  output logic [3:0]  points,
  output logic [3:0]  blank,
  output logic [3:0]  invalid,
  output logic        update,
  output logic        frame_done
);

  typedef enum logic [1:0] {WAIT, SETTLE, CAPT} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]     smp_q, smp_d;
  logic            changed, onehot, cap;
  logic [3:0]      an_n, dig_cap;
  logic [3:0]      seen_q, seen_d;
  logic            upd_q, frm_q, frm_d;
  logic [3:0][3:0] hex_q;
  logic [3:0]      pts_q, blank_q, inv_q;
  logic [4:0]      dec;

  // {valid, nibble} for the sixteen hex glyphs; anything else decodes as not-valid
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h10: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign smp_d   = {AN, SEGMENT, p};
  assign changed = (smp_d != smp_q);
  assign an_n    = ~smp_q[11:8];
  assign onehot  = (an_n != 4'h0) && ((an_n & (an_n - 4'h1)) == 4'h0);
  assign dig_cap = cap ? an_n : 4'h0;
  assign dec     = seg_dec(smp_q[7:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      smp_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
    end
  end

  // cnt tracks how many identical samples have been seen in the current run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      WAIT: begin
        if (!changed && onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(2);
        end
      end
      SETTLE: begin
        if (changed) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
          cap     = 1'b1;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPT: begin
        if (changed) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_dig
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hex_q[g]   <= 4'h0;
        pts_q[g]   <= 1'b0;
        blank_q[g] <= 1'b1;
        inv_q[g]   <= 1'b0;
      end else if (dig_cap[g]) begin
        pts_q[g] <= ~smp_q[0];
        if (dec[4]) begin
          hex_q[g]   <= dec[3:0];
          blank_q[g] <= 1'b0;
          inv_q[g]   <= 1'b0;
        end else if (smp_q[7:1] == 7'h7F) begin
          blank_q[g] <= 1'b1;
          inv_q[g]   <= 1'b0;
        end else begin
          blank_q[g] <= 1'b0;
          inv_q[g]   <= 1'b1;
        end
      end
    end
  end

  // the capture that completes the mask both reports the frame and starts a fresh one
  always_comb begin
    seen_d = seen_q;
    frm_d  = 1'b0;
    if (cap) begin
      if ((seen_q | dig_cap) == 4'hF) begin
        frm_d  = 1'b1;
        seen_d = 4'h0;
      end else begin
        seen_d = seen_q | dig_cap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 4'h0;
      upd_q  <= 1'b0;
      frm_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      upd_q  <= cap;
      frm_q  <= frm_d;
    end
  end

  assign hex        = hex_q;
  assign points     = pts_q;
  assign blank      = blank_q;
  assign invalid    = inv_q;
  assign update     = upd_q;
  assign frame_done = frm_q;

endmodule
